// File: rtl/gpr_pkg.sv
// Shared core configuration: register-file geometry, GPR sweep FSM states and
// writeback source selects.
package gpr_pkg;

  localparam int unsigned REG_NUM  = 32;
  localparam int unsigned REG_ID_W = $clog2(REG_NUM);

  // Writeback data source select used by the wbu.
  localparam logic [1:0] REG_WR_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_WR_SRC_LSU = 2'd1;
  localparam logic [1:0] REG_WR_SRC_CSR = 2'd2;
  localparam logic [1:0] REG_WR_SRC_PC  = 2'd3;

  typedef enum logic {
    StInit,
    StRun
  } gpr_state_e;

endpackage

// File: rtl/gpr_sb.sv
// Register scoreboard: a 2-bit pending-write counter per register, driving the
// read hazard flags and the issue back-pressure.
module gpr_sb #(
  parameter int REG_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       issue_en,
  input  logic [$clog2(REG_NUM)-1:0] issue_id,
  output logic                       issue_ready,
  input  logic                       wr_commit,
  input  logic [$clog2(REG_NUM)-1:0] wr_id,
  input  logic [$clog2(REG_NUM)-1:0] rd_id_1,
  input  logic [$clog2(REG_NUM)-1:0] rd_id_2,
  output logic                       busy_1,
  output logic                       busy_2
);
  import gpr_pkg::*;

  localparam int ID_W = $clog2(REG_NUM);

  logic [1:0] pend_q [REG_NUM];
  logic       issue_acc;

  // A full counter can still take an issue when a write to it retires now.
  assign issue_ready = run && !((pend_q[issue_id] == 2'd3) &&
                                !(wr_commit && (wr_id == issue_id)));
  assign issue_acc   = issue_en && issue_ready && (issue_id != '0);

  function automatic logic busy_of(input logic [ID_W-1:0] id);
    logic retiring;
    retiring = wr_commit && (wr_id == id) && (pend_q[id] == 2'd1);
    return run && (id != '0) && (pend_q[id] != 2'd0) && !retiring;
  endfunction

  assign busy_1 = busy_of(rd_id_1);
  assign busy_2 = busy_of(rd_id_2);

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (rst) begin
        pend_q[i] <= 2'd0;
      end else begin
        logic inc;
        logic dec;
        inc = issue_acc && (issue_id == ID_W'(i));
        dec = wr_commit && (wr_id == ID_W'(i));
        if (inc && !dec) begin
          pend_q[i] <= pend_q[i] + 2'd1;
        end else if (dec && !inc && (pend_q[i] != 2'd0)) begin
          pend_q[i] <= pend_q[i] - 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/gpr.sv
// General-purpose register file: zeroing sweep after reset, combinational
// reads with writeback bypass, and a pending-write scoreboard for hazards.
module gpr #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = gpr_pkg::REG_NUM
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst,
  input  logic                       i_wbu_valid,
  output logic                       o_gpr_ready,
  input  logic                       i_wbu_gpr_wr_en,
  input  logic [$clog2(REG_NUM)-1:0] i_wbu_gpr_wr_id,
  input  logic [DATA_WIDTH-1:0]      i_wbu_gpr_wr_data,
  input  logic [$clog2(REG_NUM)-1:0] i_idu_gpr_rd_id_1,
  input  logic [$clog2(REG_NUM)-1:0] i_idu_gpr_rd_id_2,
  output logic [DATA_WIDTH-1:0]      o_gpr_rd_data_1,
  output logic [DATA_WIDTH-1:0]      o_gpr_rd_data_2,
  output logic                       o_gpr_rd_busy_1,
  output logic                       o_gpr_rd_busy_2,
  input  logic                       i_idu_issue_en,
  input  logic [$clog2(REG_NUM)-1:0] i_idu_issue_id,
  output logic                       o_gpr_issue_ready
);
  import gpr_pkg::*;

  localparam int ID_W = $clog2(REG_NUM);

  gpr_state_e            state_q;
  logic [ID_W-1:0]       sweep_q;
  logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
  logic                  run;
  logic                  wr_commit;

  assign run         = (state_q == StRun);
  assign o_gpr_ready = run;
  assign wr_commit   = run && i_wbu_valid && i_wbu_gpr_wr_en && (i_wbu_gpr_wr_id != '0);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      case (state_q)
        StInit: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == ID_W'(REG_NUM - 1)) begin
            state_q <= StRun;
          end
        end
        StRun:   state_q <= StRun;
        default: state_q <= StInit;
      endcase
    end
  end

  // No reset on the storage so it maps onto distributed RAM; the sweep clears it.
  always_ff @(posedge i_sys_clk) begin
    if (state_q == StInit) begin
      regs_q[sweep_q] <= '0;
    end else if (wr_commit) begin
      regs_q[i_wbu_gpr_wr_id] <= i_wbu_gpr_wr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ID_W-1:0] id);
    if (!run || (id == '0)) begin
      return '0;
    end else if (wr_commit && (i_wbu_gpr_wr_id == id)) begin
      return i_wbu_gpr_wr_data;
    end
    return regs_q[id];
  endfunction

  assign o_gpr_rd_data_1 = read_port(i_idu_gpr_rd_id_1);
  assign o_gpr_rd_data_2 = read_port(i_idu_gpr_rd_id_2);

  gpr_sb #(
    .REG_NUM(REG_NUM)
  ) u_sb (
    .clk        (i_sys_clk),
    .rst        (i_sys_rst),
    .run        (run),
    .issue_en   (i_idu_issue_en),
    .issue_id   (i_idu_issue_id),
    .issue_ready(o_gpr_issue_ready),
    .wr_commit  (wr_commit),
    .wr_id      (i_wbu_gpr_wr_id),
    .rd_id_1    (i_idu_gpr_rd_id_1),
    .rd_id_2    (i_idu_gpr_rd_id_2),
    .busy_1     (o_gpr_rd_busy_1),
    .busy_2     (o_gpr_rd_busy_2)
  );

endmodule

// File: doc/gpr.md
GPR -- requirements
Module: gpr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register data width.
REQ-002 SHALL have parameter REG_NUM, default 32, the register count; ID width = $clog2(REG_NUM).
REQ-003 SHALL have port i_sys_clk  input  1  the single clock.
REQ-004 SHALL have port i_sys_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_wbu_valid  input  1  a writeback is offered (the wbu o_sys_valid).
REQ-006 SHALL have port o_gpr_ready  output  1  writeback is accepted this cycle (drives the wbu i_sys_ready).
REQ-007 SHALL have port i_wbu_gpr_wr_en  input  1  write enable.
REQ-008 SHALL have port i_wbu_gpr_wr_id  input  ID  destination register.
REQ-009 SHALL have port i_wbu_gpr_wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports i_idu_gpr_rd_id_1 and i_idu_gpr_rd_id_2  input  ID each  the source register IDs.
REQ-011 SHALL have ports o_gpr_rd_data_1 and o_gpr_rd_data_2  output  DATA_WIDTH each  the read data.
REQ-012 SHALL have ports o_gpr_rd_busy_1 and o_gpr_rd_busy_2  output  1 each  the source has a pending write (hazard).
REQ-013 SHALL have port i_idu_issue_en  input  1  an instruction with a destination register is issued.
REQ-014 SHALL have port i_idu_issue_id  input  ID  the destination being reserved.
REQ-015 SHALL have port o_gpr_issue_ready  output  1  the issue can be accepted.

Function
REQ-016 SHALL implement a two-state FSM with states INIT and RUN; reset enters INIT with the sweep counter at 0.
REQ-017 INIT SHALL write 0 to register[counter] each cycle and increment the counter; after writing REG_NUM-1 it SHALL go to RUN, so INIT lasts exactly REG_NUM cycles.
REQ-018 In INIT the outputs o_gpr_ready, o_gpr_issue_ready, rd_data_* and rd_busy_* SHALL all be 0.
REQ-019 In RUN, o_gpr_ready SHALL be 1; a write SHALL commit at the clock edge when i_wbu_valid and i_wbu_gpr_wr_en are high and wr_id != 0.
REQ-020 Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-021 Reads SHALL be combinational; if rd_id equals a committing wr_id (nonzero) in the same cycle, the read SHALL return i_wbu_gpr_wr_data (bypass).
REQ-022 Each register SHALL have a 2-bit pending counter, all cleared on reset.
REQ-023 An accepted issue (issue_en and issue_ready, id != 0) SHALL increment the counter for issue_id; a committed write SHALL decrement the counter for wr_id if it is nonzero; never below 0.
REQ-024 A simultaneous issue and write to the same ID SHALL leave that counter unchanged.
REQ-025 o_gpr_issue_ready SHALL be 0 when counter[issue_id]==3 and no write to that ID commits this cycle; otherwise it SHALL be 1 in RUN.
REQ-026 rd_busy_n SHALL be 1 when counter[rd_id_n] != 0, except when the counter is 1 and a write to that ID commits this cycle; rd_busy_n SHALL always be 0 for ID 0.
REQ-027 A write accepted with wr_en=0 SHALL complete the handshake with no state change.

Reset
REQ-028 Asserting i_sys_rst in any state, including mid-INIT, SHALL at the next edge clear all pending counters, zero the sweep counter and enter INIT; register contents are then re-zeroed by the sweep.
REQ-029 Register storage itself SHALL NOT be reset, so it stays inferable as distributed RAM; only the FSM, the sweep counter and the pending counters are reset.

Structure
REQ-030 The FSM state enum, REG_NUM and the ID width SHALL live in the shared cfg package alongside the existing REG_WR_SRC constants.
REQ-031 The pending-counter array and its busy/ready logic SHALL be a sub-module named gpr_sb.

Verification
REQ-032 Reset, then release: ready outputs are 0 for exactly 32 cycles, then 1; x1..x31 read 0.
REQ-033 Write x1=32'h1, then in the same cycle read rd_id_1=1: o_gpr_rd_data_1=32'h1 (bypass); the next cycle also reads 32'h1.
REQ-034 Write x0=32'hDEAD: x0 reads 0 and no busy flag is raised.
REQ-035 Issue x5 three times with no writes: the fourth issue to x5 sees issue_ready=0; issuing x5 in the same cycle as a write to x5 sees issue_ready=1 and the counter stays 3.
REQ-036 Issue x7, then read x7: busy=1; commit a write to x7=32'h80000000 while reading x7: busy=0 and the data is 32'h80000000 in that cycle.
REQ-037 Pulse i_sys_rst at sweep count 10 with x3 pending: all counters clear, the full 32-cycle INIT restarts, and x3 reads 0 with busy=0.
